sgnext_unpacker: RTL and testbench

Sequencer for the sign-extension datapath. It accepts one packed M-bit word holding K = M/N samples of N bits each and emits the samples one per cycle, least-significant first. Each emitted sample is sign-extended to M bits by an `sgnextN` instance. It sits between a packed-data source, such as a memory read port or byte-stream FIFO, and any M-bit consumer, with valid/ready handshakes on both sides.

---
 rtl/sgnext_pkg.sv | 19 +
 rtl/sgnextN.sv | 12 +
 rtl/sgnext_unpacker.sv | 92 +++++++++
 tb/tb_sgnext_unpacker.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgnext_pkg.sv
// Shared constants and sizing helpers for the sign-extension datapath.
package sgnext_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Number of N-bit samples packed in one M-bit word.
  function automatic int calc_k(input int m, input int n);
    return m / n;
  endfunction

  // Sample counter width; never narrower than one bit.
  function automatic int calc_cw(input int k);
    int w;
    w = $clog2(k);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sgnextN.sv
// Sign-extends an N-bit value to M bits by replicating its top bit.
module sgnextN #(
  parameter int N = 8,
  parameter int M = 32
) (
  input  logic [N-1:0] din,
  output logic [M-1:0] dout
);

  assign dout = {{(M-N){din[N-1]}}, din};

endmodule

// File: rtl/sgnext_unpacker.sv
// Splits a packed M-bit word into K = M/N samples, emitted LSB-first and extended to M bits.
// Optional zero-extension mode per word is enabled by defining SGNEXT_UNPACKER_ZEXT_EN.
module sgnext_unpacker
  import sgnext_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [M-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [M-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
`ifdef SGNEXT_UNPACKER_ZEXT_EN
  input  logic         i_zext,
`endif
  output logic         o_last
);

  generate
    if ((M % N) != 0 || N >= M || N < 2) begin : g_bad_params
      $error("sgnext_unpacker: M must be a multiple of N with 1 < N < M");
    end
  endgenerate

  localparam int K  = calc_k(M, N);
  localparam int CW = calc_cw(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  logic          state;
  logic [M-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          at_last;
  logic          word_acc;
  logic          samp_acc;
  logic [M-1:0]  sx_data;
  logic [M-1:0]  ext_data;

  assign busy    = (state == ST_BUSY);
  assign at_last = (cnt == CNT_LAST);

  // A new word may be taken in the same cycle the final sample leaves, so no bubble.
  assign o_ready  = !busy || (i_ready && at_last);
  assign o_valid  = busy;
  assign o_last   = busy && at_last;
  assign word_acc = i_valid && o_ready;
  assign samp_acc = busy && i_ready;

  sgnextN #(.N(N), .M(M)) u_sgnext (
    .din  (sr[N-1:0]),
    .dout (sx_data)
  );

`ifdef SGNEXT_UNPACKER_ZEXT_EN
  logic zext;
  assign ext_data = zext ? M'(sr[N-1:0]) : sx_data;
`else
  assign ext_data = sx_data;
`endif

  assign o_data = busy ? ext_data : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      cnt   <= '0;
`ifdef SGNEXT_UNPACKER_ZEXT_EN
      zext  <= 1'b0;
`endif
    end else if (word_acc) begin
      state <= ST_BUSY;
      sr    <= i_data;
      cnt   <= '0;
`ifdef SGNEXT_UNPACKER_ZEXT_EN
      zext  <= i_zext;
`endif
    end else if (samp_acc) begin
      if (at_last) begin
        state <= ST_IDLE;
      end else begin
        sr  <= sr >> N;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sgnext_unpacker.sv
// Scoreboard bench for sgnext_unpacker (N=8 main instance, N=16 side instance).
module tb_sgnext_unpacker;

  localparam int N = 8;
  localparam int M = 32;
  localparam int K = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic        ir;
  logic        zin;
  logic [31:0] idata;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_last;

  logic        iv16;
  logic        ir16;
  logic [31:0] idata16;
  logic        o_ready16;
  logic [31:0] o_data16;
  logic        o_valid16;
  logic        o_last16;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sgnext_unpacker #(.N(N), .M(M)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (idata),
    .i_valid (iv),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (ir),
`ifdef SGNEXT_UNPACKER_ZEXT_EN
    .i_zext  (zin),
`endif
    .o_last  (o_last)
  );

  sgnext_unpacker #(.N(16), .M(32)) u_dut16 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (idata16),
    .i_valid (iv16),
    .o_ready (o_ready16),
    .o_data  (o_data16),
    .o_valid (o_valid16),
    .i_ready (ir16),
`ifdef SGNEXT_UNPACKER_ZEXT_EN
    .i_zext  (1'b0),
`endif
    .o_last  (o_last16)
  );

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic z);
    return z ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  // Drives one cycle of inputs and reports handshakes; accepted words feed the scoreboard.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      output logic samp, output logic word);
    exp_t e;
    @(negedge clk);
    iv = v;
    idata = d;
    ir = r;
    #1;
    samp = o_valid && ir;
    word = iv && o_ready;
    if (word) begin
      for (int j = 0; j < K; j++) begin
        e.data = ext8(d[j*8 +: 8], zin);
        e.last = (j == K - 1);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 1'b0; ir = 1'b0; zin = 1'b0; idata = '0;
    iv16 = 1'b0; ir16 = 1'b0; idata16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset: valid=%b last=%b data=%h ready=%b required 0 0 00000000 1",
               o_valid, o_last, o_data, o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic s, w;
    exp_t e;
    int popped = 0;
    zin = 1'b0;
    step(1'b1, 32'h80FF7F01, 1'b1, s, w);
    checks++;
    if (w !== 1'b1) begin fails++; $display("[TB] FAIL basic_accept: got %b need 1", w); end
    for (int c = 0; c < 12 && popped < K; c++) begin
      step(1'b0, 32'h0, 1'b1, s, w);
      if (s) begin
        checks++;
        if (o_ready !== (popped == K - 1)) begin
          fails++;
          $display("[TB] FAIL basic_ready[%0d]: got %b need %b", popped, o_ready, popped == K - 1);
        end
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL basic_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL basic_sample[%0d]: got %h/%b need %h/%b", popped, o_data, o_last, e.data, e.last);
          end
        end
        popped++;
      end
    end
    checks++;
    if (popped != K) begin fails++; $display("[TB] FAIL basic_count: got %0d need %0d", popped, K); end
    step(1'b0, 32'h0, 1'b1, s, w);
    checks++;
    if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle: valid=%b need 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    logic s, w;
    exp_t e;
    int popped = 0;
    int accepted = 0;
    zin = 1'b0;
    for (int c = 0; c < 20 && popped < 2 * K; c++) begin
      step(accepted < 2, (accepted == 0) ? 32'h80FF7F01 : 32'h01020304, 1'b1, s, w);
      if (popped > 0) begin
        checks++;
        if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_gap: valid=%b need 1 after %0d samples", o_valid, popped); end
      end
      if (w && accepted == 1) begin
        checks++;
        if (o_last !== 1'b1) begin fails++; $display("[TB] FAIL b2b_overlap: last=%b need 1", o_last); end
      end
      if (s) begin
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL b2b_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL b2b_sample[%0d]: got %h/%b need %h/%b", popped, o_data, o_last, e.data, e.last);
          end
        end
        popped++;
      end
      if (w) accepted++;
    end
    checks++;
    if (popped != 2 * K || accepted != 2) begin
      fails++; $display("[TB] FAIL b2b_count: samples %0d words %0d need 8 2", popped, accepted);
    end
  endtask

  task automatic test_backpressure();
    logic s, w, r;
    exp_t e;
    int popped = 0;
    int stall = 0;
    zin = 1'b0;
    step(1'b1, 32'h80FF7F01, 1'b1, s, w);
    for (int c = 0; c < 20 && popped < K; c++) begin
      r = !(popped == 2 && stall < 3);
      step(1'b0, 32'h0, r, s, w);
      if (!r) begin
        stall++;
        checks++;
        if (o_data !== 32'hFFFFFFFF || o_last !== 1'b0 || o_valid !== 1'b1) begin
          fails++;
          $display("[TB] FAIL bp_hold[%0d]: got %h/%b/%b need ffffffff/0/1", stall, o_data, o_last, o_valid);
        end
      end
      if (s) begin
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL bp_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL bp_sample[%0d]: got %h/%b need %h/%b", popped, o_data, o_last, e.data, e.last);
          end
        end
        popped++;
      end
    end
    checks++;
    if (popped != K || stall != 3) begin fails++; $display("[TB] FAIL bp_count: samples %0d stalls %0d need 4 3", popped, stall); end
  endtask

  task automatic test_reset_mid();
    logic s, w;
    exp_t e;
    int popped = 0;
    zin = 1'b0;
    step(1'b1, 32'h80FF7F01, 1'b1, s, w);
    for (int c = 0; c < 10 && popped < 2; c++) begin
      step(1'b0, 32'h0, 1'b1, s, w);
      if (s) popped++;
    end
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; ir = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1 || o_last !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset: valid=%b data=%h ready=%b last=%b need 0 00000000 1 0", o_valid, o_data, o_ready, o_last);
    end
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    popped = 0;
    step(1'b1, 32'h01020304, 1'b1, s, w);
    for (int c = 0; c < 12 && popped < K; c++) begin
      step(1'b0, 32'h0, 1'b1, s, w);
      if (s) begin
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL midreset_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL midreset_sample[%0d]: got %h/%b need %h/%b", popped, o_data, o_last, e.data, e.last);
          end
        end
        popped++;
      end
    end
    checks++;
    if (popped != K) begin fails++; $display("[TB] FAIL midreset_count: got %0d need %0d", popped, K); end
  endtask

  task automatic test_n16();
    @(negedge clk);
    iv16 = 1'b1; idata16 = 32'h80007FFF; ir16 = 1'b1;
    #1;
    checks++;
    if (o_ready16 !== 1'b1) begin fails++; $display("[TB] FAIL n16_ready: got %b need 1", o_ready16); end
    @(negedge clk);
    iv16 = 1'b0;
    #1;
    checks++;
    if (o_valid16 !== 1'b1 || o_data16 !== 32'h00007FFF || o_last16 !== 1'b0) begin
      fails++; $display("[TB] FAIL n16_s0: got %b/%h/%b need 1/00007fff/0", o_valid16, o_data16, o_last16);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_valid16 !== 1'b1 || o_data16 !== 32'hFFFF8000 || o_last16 !== 1'b1) begin
      fails++; $display("[TB] FAIL n16_s1: got %b/%h/%b need 1/ffff8000/1", o_valid16, o_data16, o_last16);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_valid16 !== 1'b0) begin fails++; $display("[TB] FAIL n16_idle: valid=%b need 0", o_valid16); end
  endtask

`ifdef SGNEXT_UNPACKER_ZEXT_EN
  task automatic test_zext();
    logic s, w;
    exp_t e;
    int popped = 0;
    zin = 1'b1;
    step(1'b1, 32'h80FF7F01, 1'b1, s, w);
    for (int c = 0; c < 12 && popped < K; c++) begin
      zin = popped[0];
      step(1'b0, 32'h0, 1'b1, s, w);
      if (s) begin
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL zext_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL zext_sample[%0d]: got %h/%b need %h/%b", popped, o_data, o_last, e.data, e.last);
          end
        end
        popped++;
      end
    end
    checks++;
    if (popped != K) begin fails++; $display("[TB] FAIL zext_count: got %0d need %0d", popped, K); end
    zin = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic s, w;
    exp_t e;
    for (int c = 0; c < 200 + 60; c++) begin
`ifdef SGNEXT_UNPACKER_ZEXT_EN
      zin = 1'($urandom_range(0, 1));
`endif
      if (c < 200)
        step(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0, s, w);
      else
        step(1'b0, 32'h0, 1'b1, s, w);
      if (s) begin
        checks++;
        if (sbq.size() == 0) begin
          fails++; $display("[TB] FAIL rand_sb: unexpected sample %h", o_data);
        end else begin
          e = sbq.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            fails++;
            $display("[TB] FAIL rand_sample[c=%0d]: got %h/%b need %h/%b", c, o_data, o_last, e.data, e.last);
          end
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin fails++; $display("[TB] FAIL rand_drain: %0d samples left need 0", sbq.size()); end
    zin = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_n16();
`ifdef SGNEXT_UNPACKER_ZEXT_EN
    test_zext();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
